// File: rtl/bcd_seg_scan.sv
// Four-digit multiplexed 7-segment scanner for a BCD word, with frame-aligned value updates.
// Optional leading-zero blanking is enabled by defining LZB_EN.
module bcd_seg_scan #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd,
  input  logic        bcd_valid,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done
);
  // bcd_valid is a one-cycle strobe with no ready: the block accepts bcd on
  // every cycle bcd_valid is high, and a later strobe overwrites an earlier one.
  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shown_q, shown_d;
  logic [15:0]   pending_q, pending_d;
  logic          pend_flag_q, pend_flag_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          frame_done_q, frame_done_d;

  logic          tick;
  logic          wrap;
  logic [3:0]    nib;
  logic          blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h06;
      4'hF:    s = 7'h3F;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  always_comb begin
    tick         = (presc_q == PW'(SCAN_DIV - 1));
    wrap         = tick && (idx_q == 2'd3);
    presc_d      = tick ? '0 : presc_q + PW'(1);
    idx_d        = tick ? idx_q + 2'd1 : idx_q;
    shown_d      = shown_q;
    pending_d    = pending_q;
    pend_flag_d  = pend_flag_q;
    frame_done_d = wrap;

    if (wrap) begin
      // A strobe landing on the wrap cycle bypasses pending entirely.
      if (bcd_valid) begin
        shown_d = bcd;
      end else if (pend_flag_q) begin
        shown_d = pending_q;
      end
      pend_flag_d = 1'b0;
    end else if (bcd_valid) begin
      pending_d   = bcd;
      pend_flag_d = 1'b1;
    end

    nib = shown_q[{idx_q, 2'b00} +: 4];
`ifdef LZB_EN
    blank = (idx_q != 2'd0) && ((shown_q >> {idx_q, 2'b00}) == 16'h0000);
`else
    blank = 1'b0;
`endif
    seg_d = blank ? 7'h7F : seg_decode(nib);
    an_d  = ~(4'b0001 << idx_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= 2'd0;
      shown_q      <= 16'h0000;
      pending_q    <= 16'h0000;
      pend_flag_q  <= 1'b0;
      seg_q        <= 7'h7F;
      an_q         <= 4'hF;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shown_q      <= shown_d;
      pending_q    <= pending_d;
      pend_flag_q  <= pend_flag_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_bcd_seg_scan.sv
// Scoreboard bench for bcd_seg_scan: a cycle-count reference model predicts every output word,
// a monitor compares the DUT against it one clock later.
module tb_bcd_seg_scan;
  localparam int D     = 4;
  localparam int FRAME = 4 * D;

  logic        clk;
  logic        rst;
  logic [15:0] bcd;
  logic        bcd_valid;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  bcd_seg_scan #(.SCAN_DIV(D)) dut (
    .clk(clk), .rst(rst), .bcd(bcd), .bcd_valid(bcd_valid),
    .seg(seg), .an(an), .frame_done(frame_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected word is {frame_done, an, seg}
  logic [11:0] exp_q[$];
  logic [15:0] strobe_q[$];
  logic [6:0]  seg_tab [16];
  int          n;
  logic [15:0] m_shown;
  int          checks;
  int          errors;

  initial begin
    seg_tab[0]  = 7'h40; seg_tab[1]  = 7'h79; seg_tab[2]  = 7'h24; seg_tab[3]  = 7'h30;
    seg_tab[4]  = 7'h19; seg_tab[5]  = 7'h12; seg_tab[6]  = 7'h02; seg_tab[7]  = 7'h78;
    seg_tab[8]  = 7'h00; seg_tab[9]  = 7'h10; seg_tab[10] = 7'h06; seg_tab[11] = 7'h7F;
    seg_tab[12] = 7'h7F; seg_tab[13] = 7'h7F; seg_tab[14] = 7'h7F; seg_tab[15] = 7'h3F;
  end

  // Output visible after edge n (n>=1 since release) shows the value that was current before that edge.
  function automatic logic [11:0] expect_out(input int cnt, input logic [15:0] s);
    int         idx;
    int         digit;
    logic [6:0] sg;
    logic [3:0] a;
    logic       fd;
    idx   = ((cnt - 1) / D) % 4;
    digit = int'((s >> (4 * idx)) & 16'h000F);
    sg    = seg_tab[digit];
`ifdef LZB_EN
    if (idx > 0 && (s >> (4 * idx)) == 16'h0000) sg = 7'h7F;
`endif
    a  = 4'hF & ~(4'b0001 << idx);
    fd = (cnt % FRAME) == 0;
    return {fd, a, sg};
  endfunction

  // reference model: a frame boundary adopts the last value strobed since the previous boundary
  always @(posedge clk) begin
    if (rst) begin
      n       = 0;
      m_shown = 16'h0000;
      strobe_q.delete();
      exp_q.push_back({1'b0, 4'hF, 7'h7F});
    end else begin
      n = n + 1;
      exp_q.push_back(expect_out(n, m_shown));
      if (bcd_valid) strobe_q.push_back(bcd);
      if (n % FRAME == 0) begin
        if (strobe_q.size() > 0) m_shown = strobe_q[$];
        strobe_q.delete();
      end
    end
  end

  // monitor
  always @(posedge clk) begin
    logic [11:0] e;
    logic [11:0] act;
    #1;
    act = {frame_done, an, seg};
    if (exp_q.size() == 0) begin
      errors = errors + 1;
      $display("FAIL no_expect: got %h, no expected entry queued", act);
    end else begin
      e = exp_q.pop_front();
      checks = checks + 1;
      if (act !== e) begin
        errors = errors + 1;
        $display("FAIL out_word t=%0t n=%0d: got fd=%b an=%b seg=%h, expected fd=%b an=%b seg=%h",
                 $time, n, act[11], act[10:7], act[6:0], e[11], e[10:7], e[6:0]);
      end
    end
  end

  // driver tasks
  task automatic drive(input logic v, input logic [15:0] d);
    @(negedge clk);
    bcd_valid = v;
    bcd       = d;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(1'b0, 16'h0000);
  endtask

  task automatic wait_phase(input int p);
    int guard;
    guard = 0;
    while ((n % FRAME) != p && guard < 2 * FRAME) begin
      idle(1);
      guard++;
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst       = 1'b1;
    bcd_valid = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] specials [6];
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bcd_valid = 1'b0;
    bcd       = 16'h0000;
    specials[0] = 16'hFFFA; specials[1] = 16'h0042; specials[2] = 16'h0000;
    specials[3] = 16'h1000; specials[4] = 16'h1234; specials[5] = 16'h9876;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(40);

    wait_phase(5);
    drive(1'b1, 16'h1234);
    idle(40);

    wait_phase(2);
    drive(1'b1, 16'h5555);
    idle(3);
    drive(1'b1, 16'h9876);
    idle(40);

    wait_phase(FRAME - 1);
    drive(1'b1, 16'hFFFA);
    idle(40);

    wait_phase(3);
    drive(1'b1, 16'h0777);
    idle(4);
    do_reset(2);
    idle(40);

    drive(1'b1, 16'h0042); idle(40);
    drive(1'b1, 16'h0000); idle(40);
    drive(1'b1, 16'h1000); idle(40);

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 2) == 0) drive(1'b1, specials[$urandom_range(0, 5)]);
        else                           drive(1'b1, 16'($urandom));
      end else begin
        drive(1'b0, 16'($urandom));
      end
    end

    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_seg_scan.md
Name: bcd_seg_scan

Overview:
- Downstream consumer of the 14-bit-signed-to-BCD converter.
- Takes its 16-bit, 4-digit BCD word and drives a multiplexed, common-anode, 4-digit 7-segment display. Segments and anodes are both active-low.
- Captures each new value into a pending register and promotes it to the displayed value only at a frame boundary, so the display never shows a mix of two values.
- Decodes the converter's negative/error code 16'hFFFA so it reads "---E" on the display.

Parameters:
- SCAN_DIV, 50000: clock cycles per digit slot (1 kHz digit rate at 50 MHz). Legal range is 2 to 2^20.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- bcd  input  16  BCD word. [3:0] is digit 0 (rightmost); [15:12] is digit 3.
- bcd_valid  input  1  one-cycle strobe; bcd is sampled on every cycle where this is high.
- seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.
- an  output  4  anode select, active-low, one-hot; an[0] selects digit 0.
- frame_done  output  1  one-cycle pulse when the digit index wraps from 3 to 0.

Behaviour:
- Reset (rst high at a clk edge):
  - Outputs: seg=7'h7F, an=4'hF, frame_done=0.
  - Internal: prescaler=0, digit index=0, shown=16'h0000, pending=16'h0000, pend_flag=0.
- First edge after rst falls: an=4'b1110, seg shows digit 0 of shown. With shown=0, seg=7'h40.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - The cycle it wraps is the digit tick. On the tick the digit index increments modulo 4.
- Timing: all outputs are registered. seg and an change on the same edge, one clock after the index or shown value updates, so each digit slot lasts exactly SCAN_DIV clocks.
- Capture:
  - On every cycle with bcd_valid high: pending <= bcd, pend_flag <= 1.
  - Back-to-back strobes within one frame: the last write wins.
- Frame wrap (digit tick while index==3):
  - Index goes to 0 and frame_done pulses high for that one cycle.
  - If pend_flag is set: shown <= pending, pend_flag <= 0.
  - If bcd_valid is high on the wrap cycle: the incoming bcd goes straight into shown and pend_flag ends at 0 (bypass).
- Decode, nibble to active-low seg value:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - A='E'=06, F='-'=3F.
  - B, C, D, E are blank (7F).
- rst asserted mid-frame: at that edge the block returns to the reset state and any pending value is discarded.
- No arithmetic or range checking is done on bcd; every nibble is decoded independently.

Optional Feature:
- Macro: LZB_EN (leading-zero blanking).
- Defined:
  - Digit k (k = 3, 2, 1) shows blank (7F) when nibble k and every higher nibble of shown are 0.
  - Digit 0 is never blanked.
  - Any nonzero nibble, including A–F, stops blanking for itself and all lower digits.
  - Example: 16'h0042 displays "  42". 16'h0000 displays "   0".
- Undefined: all four digits are always decoded. Example: 16'h0042 displays "0042".

Test Plan (SCAN_DIV=4):
- Reset, then idle:
  - During reset: seg=7F, an=F.
  - Then an cycles 1110, 1101, 1011, 0111, each held 4 clocks.
  - With LZB_EN undefined: seg=40 on every digit.
  - frame_done pulses once every 16 clocks.
- Strobe bcd=16'h1234 mid-frame:
  - Display holds the old value until the next frame_done.
  - Next frame shows digit 0 = 4 (19), digit 1 = 3 (30), digit 2 = 2 (24), digit 3 = 1 (79).
- Strobe 16'h5555 then 16'h9876 within one frame: next frame shows 9876 only; 5555 never appears.
- bcd_valid with 16'hFFFA exactly on the wrap cycle:
  - The frame starting at that edge shows digit 0 = 06 ('E') and digits 1–3 = 3F ('-').
- Reset asserted while pend_flag=1 with pending=16'h0777: after release, the display shows 0000 and 0777 never appears.
- With LZB_EN defined:
  - 16'h0042 gives digits 3 and 2 = 7F, digit 1 = 19, digit 0 = 24.
  - 16'h0000 gives only digit 0 lit (40).
  - 16'h1000 gives all four digits lit.
